// File: rtl/music_sequencer.sv
// Sheet-RAM music sequencer: plays one of N_SONGS songs, advancing entries on start_of_frame at a run-time tempo.
// Optional MUSIC_SEQ_TRANSPOSE_EN adds a transpose input applied combinationally to tone_key.
module music_sequencer #(
    parameter int N_SONGS   = 4,
    parameter int MAX_NOTES = 16,
    parameter int DEF_TEMPO = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_of_frame,
    input  logic                         play_start,
    input  logic                         play_stop,
    input  logic [$clog2(N_SONGS)-1:0]   song_sel,
    input  logic                         loop_mode,
    input  logic [7:0]                   tempo,
    input  logic                         wr_en,
    input  logic [$clog2(N_SONGS)-1:0]   wr_song,
    input  logic [$clog2(MAX_NOTES)-1:0] wr_addr,
    input  logic [7:0]                   wr_data,
`ifdef MUSIC_SEQ_TRANSPOSE_EN
    input  logic [3:0]                   transpose,
`endif
    output logic [3:0]                   tone_key,
    output logic                         sound_enable,
    output logic                         busy,
    output logic                         song_done,
    output logic [$clog2(MAX_NOTES)-1:0] note_index
);
    localparam int SW = $clog2(N_SONGS);
    localparam int NW = $clog2(MAX_NOTES);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   song_q, song_d;
    logic            loop_q, loop_d;
    logic [NW-1:0]   idx_q, idx_d;
    logic [7:0]      frame_q, frame_d;
    logic [1:0]      step_q, step_d;
    logic [7:0]      tempo_q, tempo_d;
    logic            done_q, done_d;
    logic [7:0]      ram_q [N_SONGS][MAX_NOTES];

    logic [7:0]      entry;
    logic [7:0]      tempo_lim;
    logic [3:0]      tone_out;

    // Song 0 holds the original fixed theme; everything else is an immediate silent end.
    function automatic logic [7:0] reset_entry(input int s, input int n);
        logic [7:0] e;
        e = 8'h90;
        if (s == 0) begin
            case (n)
                0, 1:    e = 8'h05;
                2, 3:    e = 8'h00;
                4:       e = 8'h01;
                5:       e = 8'h83;
                default: e = 8'h90;
            endcase
        end
        return e;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            song_q  <= '0;
            loop_q  <= 1'b0;
            idx_q   <= '0;
            frame_q <= '0;
            step_q  <= '0;
            tempo_q <= 8'(DEF_TEMPO);
            done_q  <= 1'b0;
            for (int s = 0; s < N_SONGS; s++) begin
                for (int n = 0; n < MAX_NOTES; n++) begin
                    ram_q[SW'(s)][NW'(n)] <= reset_entry(s, n);
                end
            end
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            loop_q  <= loop_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            step_q  <= step_d;
            tempo_q <= tempo_d;
            done_q  <= done_d;
            if (wr_en) begin
                ram_q[wr_song][wr_addr] <= wr_data;
            end
        end
    end

    assign entry     = ram_q[song_q][idx_q];
    assign tempo_lim = (tempo_q == 8'd0) ? 8'd1 : tempo_q;

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        loop_d  = loop_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        step_d  = step_q;
        tempo_d = tempo_q;
        done_d  = 1'b0;
        if (play_stop) begin
            state_d = IDLE;
        end else if (play_start) begin
            state_d = PLAY;
            song_d  = song_sel;
            loop_d  = loop_mode;
            idx_d   = '0;
            frame_d = '0;
            step_d  = '0;
            tempo_d = tempo;
        end else if (state_q == PLAY && start_of_frame) begin
            frame_d = frame_q + 8'd1;
            // Step boundary: the compare uses the tempo captured at the previous boundary.
            if (frame_q == tempo_lim - 8'd1) begin
                frame_d = '0;
                tempo_d = tempo;
                step_d  = step_q + 2'd1;
                if (step_q == entry[6:5]) begin
                    step_d = '0;
                    if (!entry[7] && !(&idx_q)) begin
                        idx_d = idx_q + 1'b1;
                    end else if (loop_q) begin
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

`ifdef MUSIC_SEQ_TRANSPOSE_EN
    logic [3:0] shift;
    logic [4:0] sum;
    always_comb begin
        shift = (transpose > 4'd11) ? 4'd0 : transpose;
        sum   = {1'b0, entry[3:0]} + {1'b0, shift};
        if (sum >= 5'd12) begin
            sum = sum - 5'd12;
        end
        tone_out = (entry[3:0] > 4'd11) ? entry[3:0] : sum[3:0];
    end
`else
    assign tone_out = entry[3:0];
`endif

    assign busy         = (state_q == PLAY);
    assign tone_key     = busy ? tone_out : 4'd0;
    assign sound_enable = busy & ~entry[4];
    assign song_done    = done_q;
    assign note_index   = idx_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a frame/step countdown model of the song player.
module tb_music_sequencer;
    localparam int NS = 4;
    localparam int MN = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_of_frame = 1'b0;
    logic       play_start = 1'b0;
    logic       play_stop = 1'b0;
    logic [1:0] song_sel = '0;
    logic       loop_mode = 1'b0;
    logic [7:0] tempo = 8'd2;
    logic       wr_en = 1'b0;
    logic [1:0] wr_song = '0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
`ifdef MUSIC_SEQ_TRANSPOSE_EN
    logic [3:0] transpose = 4'd9;
`endif
    logic [3:0] tone_key;
    logic       sound_enable;
    logic       busy;
    logic       song_done;
    logic [3:0] note_index;

    int checks = 0;
    int errors = 0;

    music_sequencer #(.N_SONGS(NS), .MAX_NOTES(MN), .DEF_TEMPO(6)) dut (
        .clk(clk), .reset(reset), .start_of_frame(start_of_frame),
        .play_start(play_start), .play_stop(play_stop), .song_sel(song_sel),
        .loop_mode(loop_mode), .tempo(tempo), .wr_en(wr_en), .wr_song(wr_song),
        .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef MUSIC_SEQ_TRANSPOSE_EN
        .transpose(transpose),
`endif
        .tone_key(tone_key), .sound_enable(sound_enable), .busy(busy),
        .song_done(song_done), .note_index(note_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         song0_tone [6] = '{5, 5, 0, 0, 1, 3};
    logic [7:0] m_ram [NS][MN];
    logic [7:0] m_e;
    bit         m_busy, m_loop, m_done;
    int         m_song, m_idx, m_steps, m_frames_left;

    function automatic int eff(input logic [7:0] t);
        return (t == 8'd0) ? 1 : int'(t);
    endfunction

    function automatic int xp(input int t);
`ifdef MUSIC_SEQ_TRANSPOSE_EN
        int sh;
        sh = (transpose > 4'd11) ? 0 : int'(transpose);
        return (t < 12) ? (t + sh) % 12 : t;
`else
        return t;
`endif
    endfunction

    task automatic m_reset();
        for (int s = 0; s < NS; s++)
            for (int n = 0; n < MN; n++) m_ram[s][n] = 8'h90;
        for (int n = 0; n < 6; n++) m_ram[0][n] = 8'(song0_tone[n]) | ((n == 5) ? 8'h80 : 8'h00);
        m_busy = 0; m_loop = 0; m_done = 0;
        m_song = 0; m_idx = 0; m_steps = 0; m_frames_left = 1;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reset();
        end else begin
            m_e = m_ram[m_song][m_idx];
            m_done = 0;
            if (play_stop) begin
                m_busy = 0;
            end else if (play_start) begin
                m_busy = 1; m_song = int'(song_sel); m_loop = loop_mode;
                m_idx = 0; m_steps = 0; m_frames_left = eff(tempo);
            end else if (m_busy && start_of_frame) begin
                m_frames_left--;
                if (m_frames_left == 0) begin
                    m_frames_left = eff(tempo);
                    m_steps = (m_steps + 1) % 4;
                    if (m_steps == (int'(m_e[6:5]) + 1) % 4) begin
                        m_steps = 0;
                        if (!m_e[7] && m_idx < MN - 1) m_idx++;
                        else if (m_loop) m_idx = 0;
                        else begin m_busy = 0; m_done = 1; end
                    end
                end
            end
            if (wr_en) m_ram[wr_song][wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("mdl_tone_key", tone_key, m_busy ? xp(int'(m_ram[m_song][m_idx][3:0])) : 0);
            check("mdl_sound_enable", sound_enable, m_busy && !m_ram[m_song][m_idx][4]);
            check("mdl_busy", busy, m_busy);
            check("mdl_song_done", song_done, m_done);
            check("mdl_note_index", note_index, m_idx);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic frame();
        start_of_frame = 1'b1; cyc(); start_of_frame = 1'b0; cyc();
    endtask

    task automatic start_song(input int s, input bit lp, input logic [7:0] t);
        song_sel = 2'(s); loop_mode = lp; tempo = t;
        play_start = 1'b1; cyc(); play_start = 1'b0;
    endtask

    task automatic write_entry(input int s, input int a, input logic [7:0] d);
        wr_song = 2'(s); wr_addr = 4'(a); wr_data = d;
        wr_en = 1'b1; cyc(); wr_en = 1'b0;
    endtask

    int exp1 [6];

    initial begin
`ifdef MUSIC_SEQ_TRANSPOSE_EN
        exp1 = '{2, 2, 9, 9, 10, 0};
`else
        exp1 = '{5, 5, 0, 0, 1, 3};
`endif
        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_tone_key", tone_key, 0);
        check("rst_sound_enable", sound_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_song_done", song_done, 0);
        check("rst_note_index", note_index, 0);

        // Song 0 one-shot at tempo 2
        cyc();
        start_song(0, 0, 8'd2);
        for (int f = 0; f < 12; f++) begin
            @(negedge clk);
            check("t1_tone", tone_key, exp1[f / 2]);
            check("t1_busy", busy, 1);
            start_of_frame = 1'b1; cyc(); start_of_frame = 1'b0;
            @(negedge clk);
            check("t1_done_pulse", song_done, f == 11);
            check("t1_busy_after", busy, f != 11);
            cyc();
        end
        @(negedge clk);
        check("t1_done_cleared", song_done, 0);
        check("t1_quiet", sound_enable, 0);

        // Single long looping entry
        write_entry(1, 0, 8'hE7);
        start_song(1, 1, 8'd3);
        for (int f = 0; f < 13; f++) begin
            @(negedge clk);
            check("t2_tone", tone_key, xp(7));
            check("t2_idx", note_index, 0);
            check("t2_busy", busy, 1);
            check("t2_no_done", song_done, 0);
            frame();
        end
        play_stop = 1'b1; cyc(); play_stop = 1'b0;
        @(negedge clk);
        check("t2_stop_busy", busy, 0);
        check("t2_stop_done", song_done, 0);

        // Stop beats start in the same cycle
        start_song(0, 0, 8'd2);
        repeat (6) frame();
        @(negedge clk);
        check("t3_idx", note_index, 3);
        play_stop = 1'b1; play_start = 1'b1; cyc(); play_stop = 1'b0; play_start = 1'b0;
        @(negedge clk);
        check("t3_busy", busy, 0);
        check("t3_done", song_done, 0);

        // Tempo 0 behaves as 1
        start_song(0, 0, 8'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t4_idx", note_index, k);
            start_of_frame = 1'b1; cyc(); start_of_frame = 1'b0;
        end
        @(negedge clk);
        check("t4_done", song_done, 1);
        cyc();

        // Tempo change lands at the next boundary, then reset mid-song
        start_song(0, 0, 8'd2);
        repeat (4) frame();
        @(negedge clk);
        check("t5_idx2", note_index, 2);
        tempo = 8'd5;
        write_entry(0, 0, 8'h0A);
        repeat (2) frame();
        @(negedge clk);
        check("t5_idx3", note_index, 3);
        repeat (4) frame();
        @(negedge clk);
        check("t5_idx3_hold", note_index, 3);
        frame();
        @(negedge clk);
        check("t5_idx4", note_index, 4);
        @(posedge clk); #1; reset = 1'b1; #2;
        check("t5_rst_tone", tone_key, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_idx", note_index, 0);
        check("t5_rst_sound", sound_enable, 0);
        cyc(); reset = 1'b0;
        start_song(0, 0, 8'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t5_ram_restored", tone_key, exp1[k]);
            frame();
        end

        // Rest entry is silent but still playing
        write_entry(2, 0, 8'h9B);
        start_song(2, 0, 8'd2);
        @(negedge clk);
        check("t6_rest_sound", sound_enable, 0);
        check("t6_rest_busy", busy, 1);
`ifdef MUSIC_SEQ_TRANSPOSE_EN
        check("t6_rest_tone", tone_key, 8);
`else
        check("t6_rest_tone", tone_key, 11);
`endif
        play_stop = 1'b1; cyc(); play_stop = 1'b0;

        // Randomized run against the model
        for (int c = 0; c < 6000; c++) begin
            start_of_frame = ($urandom_range(0, 2) == 0);
            play_start = ($urandom_range(0, 39) == 0);
            play_stop = ($urandom_range(0, 119) == 0);
            song_sel = 2'($urandom_range(0, NS - 1));
            loop_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) tempo = 8'($urandom_range(0, 4));
            wr_en = ($urandom_range(0, 7) == 0);
            wr_song = 2'($urandom_range(0, NS - 1));
            wr_addr = 4'($urandom_range(0, MN - 1));
            wr_data = 8'($urandom_range(0, 255));
`ifdef MUSIC_SEQ_TRANSPOSE_EN
            if ($urandom_range(0, 99) == 0) transpose = 4'($urandom_range(0, 15));
`endif
            if ($urandom_range(0, 1999) == 0) reset = 1'b1;
            cyc();
            reset = 1'b0;
        end
        start_of_frame = 1'b0; play_start = 1'b0; play_stop = 1'b0; wr_en = 1'b0;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
